// File: rtl/sr8_ctrl.sv
// USB RX bit-timing and byte-framing controller for the 8-bit shift register.
// Ports: clk, rst (async high), rcving, d_edge, d_orig -> shift_enable,
//   byte_received, stuff_err, byte_abort, bit_cnt[2:0].
module sr8_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       d_orig,
  output logic       shift_enable,
  output logic       byte_received,
  output logic       stuff_err,
  output logic       byte_abort,
  output logic [2:0] bit_cnt
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_RESYNC = PW'(1);
  localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] phase, phase_nx;
  logic [OW-1:0] ones_cnt, ones_nx;
  logic [2:0]    bit_nx;
  logic          byte_nx, err_nx, abort_nx;
  logic          sample, stuffed;

  // rcving low wins over a coincident sample point.
  assign sample  = (state == ACTIVE) && rcving && (phase == PH_SAMPLE);
  assign stuffed = (ones_cnt == ONES_MAX);
  assign shift_enable = sample && !stuffed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      ones_cnt      <= '0;
      bit_cnt       <= '0;
      byte_received <= 1'b0;
      stuff_err     <= 1'b0;
      byte_abort    <= 1'b0;
    end else begin
      state         <= state_nx;
      phase         <= phase_nx;
      ones_cnt      <= ones_nx;
      bit_cnt       <= bit_nx;
      byte_received <= byte_nx;
      stuff_err     <= err_nx;
      byte_abort    <= abort_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    ones_nx  = ones_cnt;
    bit_nx   = bit_cnt;
    byte_nx  = 1'b0;
    err_nx   = 1'b0;
    abort_nx = 1'b0;
    unique case (state)
      IDLE: begin
        phase_nx = '0;
        ones_nx  = '0;
        bit_nx   = '0;
        if (rcving) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (!rcving) begin
          state_nx = IDLE;
          phase_nx = '0;
          ones_nx  = '0;
          bit_nx   = '0;
          abort_nx = (bit_cnt != 3'd0);
        end else begin
          // The edge cycle itself is phase 0, so resync lands on 1.
          if (d_edge)
            phase_nx = PH_RESYNC;
          else if (phase == PH_LAST)
            phase_nx = '0;
          else
            phase_nx = phase + 1'b1;
          if (sample) begin
            if (stuffed) begin
              ones_nx = '0;
              if (d_orig) begin
                err_nx   = 1'b1;
                state_nx = ERR;
              end
            end else begin
              bit_nx  = bit_cnt + 3'd1;
              byte_nx = (bit_cnt == 3'd7);
              ones_nx = d_orig ? ones_cnt + 1'b1 : '0;
            end
          end
        end
      end
      ERR: begin
        if (!rcving) begin
          state_nx = IDLE;
          phase_nx = '0;
          ones_nx  = '0;
          bit_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr8_ctrl.sv
// Scoreboard bench for sr8_ctrl: per-packet reference model predicts
// framing events; a monitor pops and compares them as the DUT pulses.
module tb_sr8_ctrl;

  localparam int EV_BYTE  = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, rcving, d_edge, d_orig;
  logic       shift_enable, byte_received, stuff_err, byte_abort;
  logic [2:0] bit_cnt;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [7:0] sr = 8'h00;

  sr8_ctrl dut (
    .clk(clk),
    .rst(rst),
    .rcving(rcving),
    .d_edge(d_edge),
    .d_orig(d_orig),
    .shift_enable(shift_enable),
    .byte_received(byte_received),
    .stuff_err(stuff_err),
    .byte_abort(byte_abort),
    .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Downstream shift register, LSB first (new bit enters at MSB).
  always @(posedge clk)
    if (shift_enable) sr <= {d_orig, sr[7:1]};

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_ev(int kind, logic [7:0] data);
    ev_t ev;
    ev.kind = kind;
    ev.data = data;
    exp_q.push_back(ev);
  endfunction

  function automatic void pop_cmp(int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      ev = exp_q.pop_front();
      check("event_kind", kind, ev.kind);
      if (kind == EV_BYTE) check("byte_data", int'(sr), int'(ev.data));
    end
  endfunction

  // Monitor: every output pulse must match the next predicted event.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_received) pop_cmp(EV_BYTE);
      if (stuff_err)     pop_cmp(EV_ERR);
      if (byte_abort)    pop_cmp(EV_ABORT);
    end
  end

  // Bits are sent one per 8 clocks starting at ACTIVE entry; rcving
  // drops in the final phase of the last bit.
  task automatic run_packet(input logic bits[$]);
    int   n = bits.size();
    logic sh[$];
    logic brk[$];
    logic erb[$];
    int   bc[$];
    int   ones = 0;
    int   nb = 0;
    logic [7:0] acc = 8'h00;
    bit   err = 0;
    bit   exp_abort;
    for (int k = 0; k < n; k++) begin
      logic s = 0;
      logic b = 0;
      logic e = 0;
      if (!err) begin
        if (ones == 6) begin
          ones = 0;
          if (bits[k]) begin
            e = 1;
            err = 1;
            push_ev(EV_ERR, 8'h00);
          end
        end else begin
          s = 1;
          acc[nb] = bits[k];
          nb++;
          ones = bits[k] ? ones + 1 : 0;
          if (nb == 8) begin
            b = 1;
            push_ev(EV_BYTE, acc);
            nb = 0;
            acc = 8'h00;
          end
        end
      end
      sh.push_back(s);
      brk.push_back(b);
      erb.push_back(e);
      bc.push_back(nb);
    end
    exp_abort = !err && (nb != 0);
    if (exp_abort) push_ev(EV_ABORT, 8'h00);

    @(negedge clk);
    rcving = 1'b1;
    d_orig = bits[0];
    for (int c = 0; c < 8 * n; c++) begin
      @(negedge clk);
      check("shift_enable", int'(shift_enable),
            int'((c % 8 == 3) && sh[c / 8]));
      check("byte_rx_time", int'(byte_received),
            int'((c % 8 == 4) && brk[c / 8]));
      check("stuff_err_time", int'(stuff_err),
            int'((c % 8 == 4) && erb[c / 8]));
      if (c % 8 == 7) begin
        check("bit_cnt", int'(bit_cnt), bc[c / 8] % 8);
        if (c / 8 + 1 < n) d_orig = bits[c / 8 + 1];
      end
    end
    rcving = 1'b0;
    @(negedge clk);
    check("abort_time", int'(byte_abort), int'(exp_abort));
    check("bit_cnt_clr", int'(bit_cnt), 0);
    check("se_idle", int'(shift_enable), 0);
    repeat (2) @(negedge clk);
  endtask

  // d_edge in cycle e restarts the bit: next sample three cycles later.
  task automatic run_resync(input int e);
    int nshift = 0;
    bit exp;
    d_orig = 1'b0;
    @(negedge clk);
    rcving = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c <= e) exp = (c % 8 == 3);
      else        exp = (c >= e + 3) && ((c - e - 3) % 8 == 0);
      check("resync_se", int'(shift_enable), int'(exp));
      if (exp) nshift++;
      d_edge = (c == e);
    end
    d_edge = 1'b0;
    if (nshift % 8 != 0) push_ev(EV_ABORT, 8'h00);
    rcving = 1'b0;
    @(negedge clk);
    check("resync_abort", int'(byte_abort), int'(nshift % 8 != 0));
    check("resync_clr", int'(bit_cnt), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic random_packets(input int cnt);
    for (int p = 0; p < cnt; p++) begin
      logic bits[$];
      int   n = $urandom_range(1, 40);
      int   bias = $urandom_range(50, 95);
      for (int i = 0; i < n; i++)
        bits.push_back($urandom_range(0, 99) < bias);
      run_packet(bits);
    end
  endtask

  initial begin
    logic q[$];
    rst = 1'b1;
    rcving = 1'b0;
    d_edge = 1'b0;
    d_orig = 1'b0;
    #1;
    check("rst_se", int'(shift_enable), 0);
    check("rst_bit_cnt", int'(bit_cnt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_pulses",
            int'({shift_enable, byte_received, stuff_err, byte_abort}), 0);
      check("idle_bit_cnt", int'(bit_cnt), 0);
    end

    q = '{1, 0, 1, 0, 0, 1, 0, 1};
    run_packet(q);

    q = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
    run_packet(q);

    q = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
    run_packet(q);

    q = '{0, 1, 1, 0, 0};
    run_packet(q);

    q = '{0, 0, 1, 1, 0, 0, 1, 1};
    run_packet(q);

    run_resync(6);
    run_resync(3);

    @(negedge clk);
    rcving = 1'b1;
    d_orig = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_bit_cnt", int'(bit_cnt), 0);
    check("midrst_se", int'(shift_enable), 0);
    check("midrst_pulses",
          int'({byte_received, stuff_err, byte_abort}), 0);
    @(negedge clk);
    rcving = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    random_packets(25);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
